// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I OP/OP-IMM/LUI decode to ALU op + operands, one registered valid/ready stage.
// Define ALU_DECODE_ILLEGAL_CNT_EN to add a saturating illegal_count output.
module alu_decode_stage #(
  parameter logic RD_ZERO_SUPPRESS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_op,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0] illegal_count
`endif
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3, OP_XOR = 5'd4,
                         OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  base_op, d_op;
  logic [31:0] d_a, d_b;
  logic        d_ill, d_rw, shift, accept;
  logic        unused_rs1_idx;
  assign opcode = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_rs1_idx = ^instr[19:15];
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  always_comb begin
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end
  always_comb begin
    d_op = OP_ADD;
    d_a = '0;
    d_b = '0;
    d_ill = 1'b1;
    shift = f3[1:0] == 2'b01;
    if (opcode == 7'b0110011) begin
      d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      d_op = f7[5] ? (f3[2] ? OP_SRA : OP_SUB) : base_op;
      d_a = rs1_data;
      d_b = rs2_data;
    end else if (opcode == 7'b0010011) begin
      d_ill = shift && !(f7 == 7'h00 || (f3[2] && f7 == 7'h20));
      d_op = (shift && f7[5]) ? OP_SRA : base_op;
      d_a = rs1_data;
      d_b = shift ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
    end else if (opcode == 7'b0110111) begin
      d_ill = 1'b0;
      d_b = {instr[31:12], 12'b0};
    end
    // Illegal bundles carry a neutral ADD 0,0 so the ALU never sees garbage
    if (d_ill) begin
      d_op = OP_ADD;
      d_a = '0;
      d_b = '0;
    end
  end
  assign d_rw = !d_ill && !(RD_ZERO_SUPPRESS && instr[11:7] == 5'd0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_op <= OP_ADD;
      operand_a <= '0;
      operand_b <= '0;
      rd <= '0;
      reg_write <= 1'b0;
      illegal <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_op <= d_op;
        operand_a <= d_a;
        operand_b <= d_b;
        rd <= instr[11:7];
        reg_write <= d_rw;
        illegal <= d_ill;
      end
    end
  end
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_count <= '0;
    else if (accept && d_ill && illegal_count != 16'hFFFF) illegal_count <= illegal_count + 16'd1;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed scoreboard bench for alu_decode_stage.
module tb_alu_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, reg_write, illegal;
  logic [4:0]  alu_op, rd;
  logic [31:0] operand_a, operand_b;
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_count;
`endif
  int checks = 0, errors = 0, exp_ill_cnt = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [4:0] f3map [8] = '{5'd0, 5'd5, 5'd8, 5'd9, 5'd4, 5'd6, 5'd3, 5'd2};

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b), .rd(rd),
    .reg_write(reg_write), .illegal(illegal)
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    , .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    exp_t m;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    m = '{op: 5'd0, a: 32'd0, b: 32'd0, rd: i[11:7], rw: 1'b0, ill: 1'b1};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        m.ill = 0; m.op = f3map[f3]; m.a = r1; m.b = r2;
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        m.ill = 0; m.op = 5'd1; m.a = r1; m.b = r2;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        m.ill = 0; m.op = 5'd7; m.a = r1; m.b = r2;
      end
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00) begin
          m.ill = 0; m.op = f3map[f3]; m.a = r1; m.b = {27'd0, i[24:20]};
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          m.ill = 0; m.op = 5'd7; m.a = r1; m.b = {27'd0, i[24:20]};
        end
      end else begin
        m.ill = 0; m.op = f3map[f3]; m.a = r1; m.b = {{20{i[31]}}, i[31:20]};
      end
    end else if (opc == 7'h37) begin
      m.ill = 0; m.b = {i[31:12], 12'd0};
    end
    m.rw = !m.ill && m.rd != 5'd0;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input exp_t x);
    chk({tag, ".alu_op"}, {27'd0, alu_op}, {27'd0, x.op});
    chk({tag, ".operand_a"}, operand_a, x.a);
    chk({tag, ".operand_b"}, operand_b, x.b);
    chk({tag, ".rd"}, {27'd0, rd}, {27'd0, x.rd});
    chk({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, x.rw});
    chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, x.ill});
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    exp_t m;
    instr = i; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    #1;
    if (in_ready) begin
      m = model(i, r1, r2);
      q.push_back(m);
      if (m.ill) exp_ill_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every bundle leaving the stage is compared against the oldest accepted one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk_bundle("out", e);
      end
    end
  end

  initial begin
    #2;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk_bundle("reset", '{op: 5'd0, a: 32'd0, b: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b0});
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    send(32'h002081B3, 32'd5, 32'd7);
    chk("add.out_valid", {31'd0, out_valid}, 32'd1);
    send(32'h402081B3, 32'd10, 32'd3);
    send(32'hFFF00293, 32'd9, 32'd9);
    send(32'h123450B7, 32'd4, 32'd4);
    send(32'h4030D093, 32'h80000000, 32'd0);
    send(32'h0020C033, 32'h55, 32'hAA);
    send(32'h0020A1B3, 32'hFFFFFFFF, 32'd1);
    send(32'h0020B1B3, 32'hFFFFFFFF, 32'd1);
    send(32'hFFFFFFFF, 32'd1, 32'd2);
    send(32'h02009093, 32'd1, 32'd2);
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    chk("illegal_count", {16'd0, illegal_count}, exp_ill_cnt);
`endif
    @(posedge clk); #1;
    chk("empty.out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    send(32'h00310233, 32'd20, 32'd22);
    instr = 32'h003100B3; rs1_data = 32'd1; rs2_data = 32'd2; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold.out_valid", {31'd0, out_valid}, 32'd1);
      chk_bundle("hold", q[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    if (in_ready) q.push_back(model(instr, rs1_data, rs2_data));
    chk("release.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("next.out_valid", {31'd0, out_valid}, 32'd1);
    chk_bundle("next", q[0]);
    #2; rst = 1'b1; #1;
    q.delete();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk_bundle("rst", '{op: 5'd0, a: 32'd0, b: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b0});
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    exp_ill_cnt = 0;
    chk("rst.illegal_count", {16'd0, illegal_count}, 32'd0);
`endif
    @(posedge clk); #3; rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h00A00513, 32'd0, 32'd0);
    chk("post_rst.out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
